uart_color_ctrl: RTL and testbench

Controller that sits directly behind the UART receiver (`UART_state`) and assembles its byte stream into color commands for the display path. It drives the receiver's `paritybit`/`stopbit` configuration and applies changes only between packets. It hunts for the header 0xAA 0x55, collects R, G and B, and checks an XOR checksum. It publishes a validated color with a one-cycle strobe and counts every aborted packet.

---
 rtl/uart_color_ctrl_pkg.sv | 29 ++
 rtl/uart_color_timer.sv | 28 ++
 rtl/uart_color_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_color_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_color_ctrl_pkg.sv
// Shared types and constants for the UART color-command controller.
package uart_color_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT1,
    ST_HUNT2,
    ST_GET_R,
    ST_GET_G,
    ST_GET_B,
    ST_GET_CHK
  } state_t;

  localparam logic [7:0] HDR_1 = 8'hAA;
  localparam logic [7:0] HDR_2 = 8'h55;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  localparam logic [1:0] CAUSE_RX_ERR   = 2'd0;
  localparam logic [1:0] CAUSE_CHECKSUM = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd2;

  // The reserved encoding falls back to no parity.
  function automatic logic [1:0] norm_parity(input logic [1:0] p);
    return (p == PAR_EVEN || p == PAR_ODD) ? p : PAR_NONE;
  endfunction

endpackage

// File: rtl/uart_color_timer.sv
// Inter-byte timeout: down-counter reloaded on every byte, expires at terminal count zero.
module uart_color_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= LOAD;
    end else if (enable && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Reload happens after the byte cycle, so zero is reached TIMEOUT cycles after it.
  assign expire = enable && (cnt == '0);

endmodule

// File: rtl/uart_color_ctrl.sv
// Packet assembler behind the UART receiver: AA 55 R G B CHK -> validated color.
// Optional inter-byte timeout enabled by defining UART_COLOR_CTRL_TIMEOUT_EN.
//
// state      | meaning
// HUNT1      | idle, waiting for header byte 0xAA; receiver config may be applied
// HUNT2      | got 0xAA, waiting for 0x55 (0xAA re-arms)
// GET_R      | waiting for red byte
// GET_G      | waiting for green byte
// GET_B      | waiting for blue byte
// GET_CHK    | waiting for XOR checksum byte
module uart_color_ctrl
  import uart_color_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop,
  input  logic             cfg_load,
  output logic [1:0]       paritybit,
  output logic             stopbit,
  input  logic [7:0]       rx_out,
  input  logic             rx_ready_out,
  input  logic [3:0]       rx_error,
  input  logic             rx_ready_error,
  output logic [7:0]       color_r,
  output logic [7:0]       color_g,
  output logic [7:0]       color_b,
  output logic             color_valid,
  output logic             abort,
  output logic [1:0]       abort_cause,
  output logic [3:0]       last_err,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t     state;
  logic [7:0] r_q, g_q, b_q;
  logic [1:0] par_shadow;
  logic       stop_shadow;
  logic       err_hit, tmo_hit, chk_ok, count_abort;

  assign busy    = (state != ST_HUNT1);
  assign err_hit = rx_ready_error && (rx_error != 4'h0);
  assign chk_ok  = (rx_out == (r_q ^ g_q ^ b_q));

`ifdef UART_COLOR_CTRL_TIMEOUT_EN
  uart_color_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_ready_out),
    .enable (busy),
    .expire (tmo_hit)
  );
`else
  // No timer in this build; TIMEOUT only keeps the parameter list uniform.
  assign tmo_hit = 1'b0 & (TIMEOUT > 0);
`endif

  // Receiver errors count even in HUNT1, where they do not strobe abort.
  assign count_abort = err_hit || tmo_hit ||
                       (rx_ready_out && state == ST_GET_CHK && !chk_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HUNT1;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      color_r     <= '0;
      color_g     <= '0;
      color_b     <= '0;
      color_valid <= 1'b0;
      abort       <= 1'b0;
      abort_cause <= CAUSE_RX_ERR;
      last_err    <= '0;
      err_count   <= '0;
      par_shadow  <= PAR_NONE;
      stop_shadow <= 1'b0;
      paritybit   <= PAR_NONE;
      stopbit     <= 1'b0;
    end else begin
      color_valid <= 1'b0;
      abort       <= 1'b0;

      if (cfg_load) begin
        par_shadow  <= norm_parity(cfg_parity);
        stop_shadow <= cfg_stop;
      end
      if (state == ST_HUNT1 && !rx_ready_out) begin
        paritybit <= par_shadow;
        stopbit   <= stop_shadow;
      end

      if (count_abort && err_count != ERR_MAX) begin
        err_count <= err_count + 1'b1;
      end

      if (err_hit) begin
        last_err <= rx_error;
        if (state != ST_HUNT1) begin
          abort       <= 1'b1;
          abort_cause <= CAUSE_RX_ERR;
        end
        state <= ST_HUNT1;
      end else if (tmo_hit) begin
        abort       <= 1'b1;
        abort_cause <= CAUSE_TIMEOUT;
        state       <= ST_HUNT1;
      end else if (rx_ready_out) begin
        case (state)
          ST_HUNT1: if (rx_out == HDR_1) state <= ST_HUNT2;
          ST_HUNT2: begin
            if (rx_out == HDR_2)      state <= ST_GET_R;
            else if (rx_out != HDR_1) state <= ST_HUNT1;
          end
          ST_GET_R: begin r_q <= rx_out; state <= ST_GET_G; end
          ST_GET_G: begin g_q <= rx_out; state <= ST_GET_B; end
          ST_GET_B: begin b_q <= rx_out; state <= ST_GET_CHK; end
          ST_GET_CHK: begin
            if (chk_ok) begin
              color_r     <= r_q;
              color_g     <= g_q;
              color_b     <= b_q;
              color_valid <= 1'b1;
            end else begin
              abort       <= 1'b1;
              abort_cause <= CAUSE_CHECKSUM;
            end
            state <= ST_HUNT1;
          end
          default: state <= ST_HUNT1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_color_ctrl.sv
// Self-checking bench for uart_color_ctrl: directed vector table, corner sequences, random vs model.
module tb_uart_color_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cfg_parity;
  logic       cfg_stop, cfg_load;
  logic [1:0] paritybit;
  logic       stopbit;
  logic [7:0] rx_out;
  logic       rx_ready_out;
  logic [3:0] rx_error;
  logic       rx_ready_error;
  logic [7:0] color_r, color_g, color_b;
  logic       color_valid, abort;
  logic [1:0] abort_cause;
  logic [3:0] last_err;
  logic [7:0] err_count;
  logic       busy;

  always #5 clk = ~clk;

  uart_color_ctrl #(.TIMEOUT(64), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_parity(cfg_parity), .cfg_stop(cfg_stop), .cfg_load(cfg_load),
    .paritybit(paritybit), .stopbit(stopbit),
    .rx_out(rx_out), .rx_ready_out(rx_ready_out),
    .rx_error(rx_error), .rx_ready_error(rx_ready_error),
    .color_r(color_r), .color_g(color_g), .color_b(color_b),
    .color_valid(color_valid), .abort(abort), .abort_cause(abort_cause),
    .last_err(last_err), .err_count(err_count), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // r g b valid abort cause last_err err_count busy parity stop
  typedef logic [43:0] ovec_t;

  function automatic ovec_t pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                 input logic v, input logic a, input logic [1:0] c,
                                 input logic [3:0] le, input logic [7:0] cnt, input logic bz,
                                 input logic [1:0] p, input logic s);
    return {r, g, b, v, a, c, le, cnt, bz, p, s};
  endfunction

  function automatic ovec_t dut_vec();
    return pack(color_r, color_g, color_b, color_valid, abort, abort_cause,
                last_err, err_count, busy, paritybit, stopbit);
  endfunction

  task automatic check(input string name, input ovec_t act, input ovec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic bv, input logic [7:0] b, input logic ev, input logic [3:0] code,
                      input logic ld, input logic [1:0] lp, input logic ls);
    rx_ready_out = bv; rx_out = b; rx_ready_error = ev; rx_error = code;
    cfg_load = ld; cfg_parity = lp; cfg_stop = ls;
    @(posedge clk);
    #1;
    rx_ready_out = 1'b0; rx_ready_error = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic byte_in(input logic [7:0] b);
    step(1'b1, b, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       bv;
    logic [7:0] b;
    logic       ev;
    logic [3:0] code;
    logic       ld;
    logic [1:0] lp;
    logic       ls;
    ovec_t      exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic bv, input logic [7:0] b, input logic ev, input logic [3:0] code,
                     input logic ld, input logic [1:0] lp, input logic ls,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                     input logic evl, input logic eab, input logic [1:0] ec,
                     input logic [3:0] ele, input logic [7:0] ecnt, input logic ebz,
                     input logic [1:0] ep, input logic es);
    vec_t t;
    t.bv = bv; t.b = b; t.ev = ev; t.code = code; t.ld = ld; t.lp = lp; t.ls = ls;
    t.exp = pack(er, eg, eb, evl, eab, ec, ele, ecnt, ebz, ep, es);
    tbl.push_back(t);
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_phase;        // 0 hunting, 1 saw 0xAA, 2 collecting payload
  logic [7:0] m_pay[$];
  logic [7:0] m_r, m_g, m_b, m_cnt;
  logic       m_valid, m_abort, m_stop, m_sh_stop;
  logic [1:0] m_cause, m_par, m_sh_par;
  logic [3:0] m_last;

  task automatic model_reset();
    m_phase = 0; m_pay.delete();
    m_r = 0; m_g = 0; m_b = 0; m_cnt = 0; m_valid = 0; m_abort = 0;
    m_cause = 0; m_last = 0; m_par = 0; m_stop = 0; m_sh_par = 0; m_sh_stop = 0;
  endtask

  task automatic model_bump();
    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
  endtask

  task automatic model_step(input logic bv, input logic [7:0] b, input logic ev, input logic [3:0] code,
                            input logic ld, input logic [1:0] lp, input logic ls);
    m_valid = 0;
    m_abort = 0;
    if (m_phase == 0 && !bv) begin
      m_par = m_sh_par;
      m_stop = m_sh_stop;
    end
    if (ld) begin
      m_sh_par = (lp == 2'd3) ? 2'd0 : lp;
      m_sh_stop = ls;
    end
    if (ev && code != 4'h0) begin
      m_last = code;
      model_bump();
      if (m_phase != 0) begin
        m_abort = 1;
        m_cause = 2'd0;
      end
      m_phase = 0;
      m_pay.delete();
    end else if (bv) begin
      if (m_phase == 0) begin
        m_phase = (b == 8'hAA) ? 1 : 0;
      end else if (m_phase == 1) begin
        m_phase = (b == 8'h55) ? 2 : (b == 8'hAA) ? 1 : 0;
      end else begin
        m_pay.push_back(b);
        if (m_pay.size() == 4) begin
          if (m_pay[3] == (m_pay[0] ^ m_pay[1] ^ m_pay[2])) begin
            m_r = m_pay[0]; m_g = m_pay[1]; m_b = m_pay[2]; m_valid = 1;
          end else begin
            m_abort = 1; m_cause = 2'd1; model_bump();
          end
          m_pay.delete();
          m_phase = 0;
        end
      end
    end
  endtask

  function automatic ovec_t model_vec();
    return pack(m_r, m_g, m_b, m_valid, m_abort, m_cause, m_last, m_cnt,
                (m_phase != 0), m_par, m_stop);
  endfunction

  logic [7:0] stim_q[$];
  logic [7:0] rr, rg, rb, rbyte;
  logic       rbv, rev, rld, rls;
  logic [3:0] rcode;
  logic [1:0] rlp;
  int         sel, k;
  logic       seen;

  initial begin
    rst = 1'b1; cfg_parity = 0; cfg_stop = 0; cfg_load = 0;
    rx_out = 0; rx_ready_out = 0; rx_error = 0; rx_ready_error = 0;

    do_reset();
    check("reset", dut_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // valid packet
    add(1, 8'hAA, 0, 0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h55, 0, 0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h12, 0, 0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h34, 0, 0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h56, 0, 0, 0, 0, 0,  8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h70, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 0, 0, 0, 0, 0, 0);
    // bad checksum
    add(1, 8'hAA, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h55, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h01, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h02, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'h03, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 1, 1, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 1, 0, 1, 0, 0, 0);
    // resync and garbage
    add(1, 8'h00, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 8'hAA, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 8'hAA, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 8'h55, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0,  8'h12, 8'h34, 8'h56, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 8'hFF, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 1, 0, 1, 0, 1, 0, 0, 0);
    // back-to-back header, then receiver error after R
    add(1, 8'hAA, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 8'h55, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 1, 0, 1, 1, 0, 0);
    add(1, 8'h01, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 8'h00, 1, 2, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 1, 0, 2, 2, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 2, 2, 0, 0, 0);
    // same-cycle byte and error: error wins
    add(1, 8'hAA, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 2, 2, 1, 0, 0);
    add(1, 8'h55, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 2, 2, 1, 0, 0);
    add(1, 8'h77, 1, 5, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 1, 0, 5, 3, 0, 0, 0);
    // error while hunting counts without abort; zero code ignored
    add(0, 8'h00, 1, 9, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 9, 4, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 9, 4, 0, 0, 0);
    // config load mid-packet is deferred until after return to HUNT1
    add(1, 8'hAA, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 9, 4, 1, 0, 0);
    add(1, 8'h55, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 9, 4, 1, 0, 0);
    add(1, 8'h10, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 9, 4, 1, 0, 0);
    add(1, 8'h20, 0, 0, 1, 1, 1,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 9, 4, 1, 0, 0);
    add(1, 8'h30, 0, 0, 0, 0, 0,  8'hFF, 8'h00, 8'h00, 0, 0, 0, 9, 4, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0,  8'h10, 8'h20, 8'h30, 1, 0, 0, 9, 4, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0,  8'h10, 8'h20, 8'h30, 0, 0, 0, 9, 4, 0, 1, 1);
    // reserved parity applied as none, one clock after the load
    add(0, 8'h00, 0, 0, 1, 3, 0,  8'h10, 8'h20, 8'h30, 0, 0, 0, 9, 4, 0, 1, 1);
    add(0, 8'h00, 0, 0, 0, 0, 0,  8'h10, 8'h20, 8'h30, 0, 0, 0, 9, 4, 0, 0, 0);
    // byte arriving in HUNT1 blocks apply; packet start defers it further
    add(0, 8'h00, 0, 0, 1, 2, 1,  8'h10, 8'h20, 8'h30, 0, 0, 0, 9, 4, 0, 0, 0);
    add(1, 8'hAA, 0, 0, 0, 0, 0,  8'h10, 8'h20, 8'h30, 0, 0, 0, 9, 4, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0,  8'h10, 8'h20, 8'h30, 0, 0, 0, 9, 4, 1, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0,  8'h10, 8'h20, 8'h30, 0, 0, 0, 9, 4, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0,  8'h10, 8'h20, 8'h30, 0, 0, 0, 9, 4, 0, 2, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].bv, tbl[i].b, tbl[i].ev, tbl[i].code, tbl[i].ld, tbl[i].lp, tbl[i].ls);
      check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // reset mid-packet discards partial bytes
    byte_in(8'hAA); byte_in(8'h55); byte_in(8'h11);
    do_reset();
    check("rst_mid", dut_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    byte_in(8'h22); byte_in(8'h33); byte_in(8'h11);
    check("rst_no_resume", dut_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // err_count saturation over 300 real aborts
    do_reset();
    for (int i = 0; i < 300; i++) begin
      byte_in(8'hAA);
      step(1'b0, 8'h00, 1'b1, 4'h1, 1'b0, 2'd0, 1'b0);
      if (i == 253)
        check("sat_254", dut_vec(), pack(0, 0, 0, 0, 1, 0, 1, 8'd254, 0, 0, 0));
      if (i == 254)
        check("sat_255", dut_vec(), pack(0, 0, 0, 0, 1, 0, 1, 8'd255, 0, 0, 0));
    end
    check("sat_300", dut_vec(), pack(0, 0, 0, 0, 1, 0, 1, 8'd255, 0, 0, 0));

    // header then silence
    do_reset();
    byte_in(8'hAA);
    byte_in(8'h55);
    seen = 1'b0;
    k = 0;
`ifdef UART_COLOR_CTRL_TIMEOUT_EN
    while (!seen && k < 100) begin
      idle();
      k++;
      if (abort) seen = 1'b1;
    end
    check("tmo_cycle", ovec_t'(k), ovec_t'(64));
    check("tmo_state", dut_vec(), pack(0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0));
`else
    for (int i = 0; i < 200; i++) begin
      idle();
      if (abort) seen = 1'b1;
    end
    check("no_tmo", dut_vec(), pack(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    check("no_tmo_abort", ovec_t'(seen), ovec_t'(0));
`endif

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    stim_q.delete();
    for (int n = 0; n < 4000; n++) begin
      if (stim_q.size() == 0) begin
        sel = $urandom_range(0, 9);
        rr = 8'($urandom_range(0, 255));
        rg = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        if (sel < 5) begin
          stim_q = '{8'hAA, 8'h55, rr, rg, rb, rr ^ rg ^ rb};
        end else if (sel < 7) begin
          stim_q = '{8'hAA, 8'h55, rr, rg, rb, (rr ^ rg ^ rb) ^ 8'h01};
        end else if (sel < 8) begin
          stim_q = '{8'hAA, 8'hAA, 8'h55, rr, rg, rb, rr ^ rg ^ rb};
        end else begin
          stim_q = '{rr, rg};
        end
      end
      rbv   = ($urandom_range(0, 3) != 0);
      rev   = ($urandom_range(0, 49) == 0);
      rcode = 4'($urandom_range(0, 15));
      rld   = ($urandom_range(0, 24) == 0);
      rlp   = 2'($urandom_range(0, 3));
      rls   = 1'($urandom_range(0, 1));
      rbyte = rbv ? stim_q.pop_front() : 8'h00;
      step(rbv, rbyte, rev, rcode, rld, rlp, rls);
      model_step(rbv, rbyte, rev, rcode, rld, rlp, rls);
      check($sformatf("rand%0d", n), dut_vec(), model_vec());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
